// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared types and constants for the SID voice allocator
//
// Holds the allocator FSM state encoding, the requester IDs used to index
// the two request ports and the default gate-low retrigger gap length.
package sid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_GAP   = 2'd2
    } sid_state_e;

    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_SEQ = 1'b1;

    localparam int RETRIG_CYCLES_DEF = 4;

endpackage

// File: rtl/sid_rr_arb.sv
// rtl/sid_rr_arb.sv - stateless 2-way round-robin arbiter
//
// Ports:
//   valid      in  2  request pending per requester
//   last_grant in  1  ID of the requester that won the previous transfer
//   grant      out 2  one-hot winner, zero when nothing is valid
module sid_rr_arb
    import sid_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // Contention: the previous winner yields.
            if (last_grant == REQ_SPI) begin
                grant[REQ_SEQ] = 1'b1;
            end else begin
                grant[REQ_SPI] = 1'b1;
            end
        end else begin
            // Zero or one requester valid: the valid vector is already one-hot.
            grant = valid;
        end
    end

endmodule

// File: rtl/sid_voice_alloc.sv
// rtl/sid_voice_alloc.sv - two-voice note allocator with retrigger and voice stealing
//
// Accepts note-on/off events from two requesters (SPI, sequencer) through a
// round-robin arbitrated valid/ready handshake and maps them onto two voices.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready [1:0]   per-requester handshake
//   req_note_on [1:0]           1 = note-on, 0 = note-off
//   req_freq_0/1 [15:0]         frequency word (note-on only)
//   req_tag_0/1 [3:0]           note ID pairing note-off with note-on
//   voice_freq_0/1 [15:0]       registered voice frequency
//   voice_gate [1:0]            registered voice gate
//   voice_busy [1:0]            voice owned by a sounding note
//   steal_count [7:0]           saturating count of voice steals
module sid_voice_alloc
    import sid_pkg::*;
#(
    parameter int RETRIG_CYCLES = RETRIG_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_note_on,
    input  logic [15:0] req_freq_0,
    input  logic [15:0] req_freq_1,
    input  logic [3:0]  req_tag_0,
    input  logic [3:0]  req_tag_1,
    output logic [15:0] voice_freq_0,
    output logic [15:0] voice_freq_1,
    output logic [1:0]  voice_gate,
    output logic [1:0]  voice_busy,
    output logic [7:0]  steal_count
);

    localparam logic [3:0] CNT_INIT = 4'(RETRIG_CYCLES - 1);

    sid_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             ev_id_q, ev_id_d;
    logic             ev_on_q, ev_on_d;
    logic [15:0]      ev_freq_q, ev_freq_d;
    logic [3:0]       ev_tag_q, ev_tag_d;
    logic             tgt_q, tgt_d;
    logic [1:0][15:0] freq_q, freq_d;
    logic [1:0]       gate_q, gate_d;
    logic [1:0]       busy_q, busy_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0][3:0]  tag_q, tag_d;
    logic             newest_q, newest_d;
    logic [7:0]       steal_q, steal_d;

    logic [1:0] grant;
    logic [1:0] match;
    logic       alloc_tgt;
    logic       alloc_steal;
    logic       load_en;
    logic       load_idx;

    sid_rr_arb u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Ready is held off during reset so nothing is accepted while state is cleared.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : 2'b00;

    // A voice matches the latched event when it is sounding for the same requester and tag.
    assign match[0] = busy_q[0] && (owner_q[0] == ev_id_q) && (tag_q[0] == ev_tag_q);
    assign match[1] = busy_q[1] && (owner_q[1] == ev_id_q) && (tag_q[1] == ev_tag_q);

    // Note-on target: retrigger, then lowest free voice, then steal the older voice.
    always_comb begin
        alloc_tgt   = 1'b0;
        alloc_steal = 1'b0;
        if (match[0]) begin
            alloc_tgt = 1'b0;
        end else if (match[1]) begin
            alloc_tgt = 1'b1;
        end else if (!busy_q[0]) begin
            alloc_tgt = 1'b0;
        end else if (!busy_q[1]) begin
            alloc_tgt = 1'b1;
        end else begin
            alloc_tgt   = ~newest_q;
            alloc_steal = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        ev_id_d      = ev_id_q;
        ev_on_d      = ev_on_q;
        ev_freq_d    = ev_freq_q;
        ev_tag_d     = ev_tag_q;
        tgt_d        = tgt_q;
        freq_d       = freq_q;
        gate_d       = gate_q;
        busy_d       = busy_q;
        owner_d      = owner_q;
        tag_d        = tag_q;
        newest_d     = newest_q;
        steal_d      = steal_q;
        load_en      = 1'b0;
        load_idx     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|(req_ready & req_valid)) begin
                    ev_id_d      = grant[1];
                    ev_on_d      = req_note_on[grant[1]];
                    ev_freq_d    = grant[1] ? req_freq_1 : req_freq_0;
                    ev_tag_d     = grant[1] ? req_tag_1 : req_tag_0;
                    last_grant_d = grant[1];
                    state_d      = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                state_d = ST_IDLE;
                if (ev_on_q) begin
                    if (alloc_steal && steal_q != 8'hFF) begin
                        steal_d = steal_q + 8'd1;
                    end
                    tgt_d = alloc_tgt;
                    if (gate_q[alloc_tgt]) begin
                        // Sounding voice: drop the gate first so the envelope restarts cleanly.
                        gate_d[alloc_tgt] = 1'b0;
                        cnt_d             = CNT_INIT;
                        state_d           = ST_GAP;
                    end else begin
                        load_en  = 1'b1;
                        load_idx = alloc_tgt;
                    end
                end else if (match[0]) begin
                    gate_d[0] = 1'b0;
                    busy_d[0] = 1'b0;
                end else if (match[1]) begin
                    gate_d[1] = 1'b0;
                    busy_d[1] = 1'b0;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    load_en  = 1'b1;
                    load_idx = tgt_q;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_en) begin
            freq_d[load_idx]  = ev_freq_q;
            gate_d[load_idx]  = 1'b1;
            busy_d[load_idx]  = 1'b1;
            owner_d[load_idx] = ev_id_q;
            tag_d[load_idx]   = ev_tag_q;
            newest_d          = load_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= REQ_SEQ;
            ev_id_q      <= REQ_SPI;
            ev_on_q      <= 1'b0;
            ev_freq_q    <= 16'd0;
            ev_tag_q     <= 4'd0;
            tgt_q        <= 1'b0;
            freq_q       <= '0;
            gate_q       <= 2'b00;
            busy_q       <= 2'b00;
            owner_q      <= 2'b00;
            tag_q        <= '0;
            newest_q     <= 1'b1;
            steal_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            ev_id_q      <= ev_id_d;
            ev_on_q      <= ev_on_d;
            ev_freq_q    <= ev_freq_d;
            ev_tag_q     <= ev_tag_d;
            tgt_q        <= tgt_d;
            freq_q       <= freq_d;
            gate_q       <= gate_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            tag_q        <= tag_d;
            newest_q     <= newest_d;
            steal_q      <= steal_d;
        end
    end

    assign voice_freq_0 = freq_q[0];
    assign voice_freq_1 = freq_q[1];
    assign voice_gate   = gate_q;
    assign voice_busy   = busy_q;
    assign steal_count  = steal_q;

endmodule

// File: tb/tb_sid_voice_alloc.sv
// tb/tb_sid_voice_alloc.sv - self-checking bench for sid_voice_alloc
module tb_sid_voice_alloc;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_note_on = 2'b00;
    logic [15:0] req_freq_0 = 16'h0;
    logic [15:0] req_freq_1 = 16'h0;
    logic [3:0]  req_tag_0 = 4'h0;
    logic [3:0]  req_tag_1 = 4'h0;
    logic [1:0]  req_ready;
    logic [15:0] voice_freq_0;
    logic [15:0] voice_freq_1;
    logic [1:0]  voice_gate;
    logic [1:0]  voice_busy;
    logic [7:0]  steal_count;

    int total = 0;
    int bad = 0;

    // Expected {gate, busy, freq_0, freq_1, steal_count} snapshots.
    logic [43:0] sb_q[$];
    logic [1:0]  gnt_q[$];
    logic [43:0] obs;
    logic [43:0] want;
    logic [1:0]  want_g;

    always #5 clk = ~clk;

    sid_voice_alloc #(.RETRIG_CYCLES(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_note_on  (req_note_on),
        .req_freq_0   (req_freq_0),
        .req_freq_1   (req_freq_1),
        .req_tag_0    (req_tag_0),
        .req_tag_1    (req_tag_1),
        .voice_freq_0 (voice_freq_0),
        .voice_freq_1 (voice_freq_1),
        .voice_gate   (voice_gate),
        .voice_busy   (voice_busy),
        .steal_count  (steal_count)
    );

    // Presents one event and returns at the negedge of cycle T+1 (T = handshake cycle).
    task automatic send(input int id, input logic on, input logic [15:0] f, input logic [3:0] t);
        int n;
        req_note_on[id] = on;
        if (id == 0) begin
            req_freq_0 = f;
            req_tag_0  = t;
        end else begin
            req_freq_1 = f;
            req_tag_1  = t;
        end
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout req=%0d got_ready=%b want_ready=1", id, req_ready[id]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b want=00", req_ready);
        end
        sb_q.push_back(44'h0);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs, want);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        int seen;
        logic saw11;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        req_note_on = 2'b00;
        req_tag_0 = 4'd9;
        req_tag_1 = 4'd9;
        req_valid = 2'b11;
        #1;
        seen = 0;
        saw11 = 1'b0;
        for (int c = 0; c < 30 && seen < 3; c++) begin
            if (req_ready == 2'b11) saw11 = 1'b1;
            if (req_ready != 2'b00) begin
                want_g = gnt_q.pop_front();
                total++;
                if (req_ready !== want_g) begin
                    bad++;
                    $display("FAIL arb_grant%0d got=%b want=%b", seen, req_ready, want_g);
                end
                seen++;
            end
            @(negedge clk);
            #1;
        end
        req_valid = 2'b00;
        total++;
        if (seen != 3) begin
            bad++;
            $display("FAIL arb_count got=%0d want=3", seen);
        end
        total++;
        if (saw11 !== 1'b0) begin
            bad++;
            $display("FAIL arb_both_ready got=%b want=0", saw11);
        end
        sb_q.push_back(44'h0);
        @(negedge clk);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL arb_unmatched_off got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_note_on();
        sb_q.push_back({2'b00, 2'b00, 16'h0000, 16'h0000, 8'd0});
        sb_q.push_back({2'b01, 2'b01, 16'h1234, 16'h0000, 8'd0});
        send(0, 1'b1, 16'h1234, 4'd3);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL note_on_t1 got=%h want=%h", obs, want);
        end
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL note_on_t2 got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_steal();
        logic err;
        sb_q.push_back({2'b11, 2'b11, 16'h1234, 16'h0555, 8'd0});
        send(1, 1'b1, 16'h0555, 4'd7);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL steal_fill got=%h want=%h", obs, want);
        end
        sb_q.push_back({2'b11, 2'b11, 16'h0800, 16'h0555, 8'd1});
        send(1, 1'b1, 16'h0800, 4'd8);
        @(negedge clk);
        err = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (voice_gate !== 2'b10) err = 1'b1;
            @(negedge clk);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL steal_gap got_err=%b want_err=0", err);
        end
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL steal_done got=%h want=%h", obs, want);
        end
        sb_q.push_back({2'b11, 2'b11, 16'h0800, 16'h0555, 8'd1});
        send(0, 1'b0, 16'h0000, 4'd3);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL steal_off_other got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_retrigger();
        logic err;
        pulse_reset();
        sb_q.push_back({2'b01, 2'b01, 16'h0100, 16'h0000, 8'd0});
        send(0, 1'b1, 16'h0100, 4'd5);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL retrig_first got=%h want=%h", obs, want);
        end
        sb_q.push_back({2'b01, 2'b01, 16'h0200, 16'h0000, 8'd0});
        send(0, 1'b1, 16'h0200, 4'd5);
        @(negedge clk);
        err = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (voice_gate !== 2'b00) err = 1'b1;
            @(negedge clk);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL retrig_gap got_err=%b want_err=0", err);
        end
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL retrig_done got=%h want=%h", obs, want);
        end
        sb_q.push_back({2'b00, 2'b00, 16'h0200, 16'h0000, 8'd0});
        send(0, 1'b0, 16'h0000, 4'd5);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL retrig_off got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_reset_in_gap();
        logic err;
        pulse_reset();
        send(0, 1'b1, 16'h0AAA, 4'd1);
        @(negedge clk);
        send(0, 1'b1, 16'h0BBB, 4'd1);
        @(negedge clk);
        rst = 1'b1;
        sb_q.push_back(44'h0);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL gap_reset got=%h want=%h", obs, want);
        end
        rst = 1'b0;
        err = 1'b0;
        for (int k = 0; k < R + 3; k++) begin
            @(negedge clk);
            if (voice_gate !== 2'b00 || voice_freq_0 !== 16'h0) err = 1'b1;
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL gap_no_regate got_err=%b want_err=0", err);
        end
        sb_q.push_back({2'b01, 2'b01, 16'h0CCC, 16'h0000, 8'd0});
        send(1, 1'b1, 16'h0CCC, 4'd2);
        @(negedge clk);
        obs = {voice_gate, voice_busy, voice_freq_0, voice_freq_1, steal_count};
        want = sb_q.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL gap_next_event got=%h want=%h", obs, want);
        end
    endtask

    task automatic test_steal_saturate();
        pulse_reset();
        send(0, 1'b1, 16'h0001, 4'd0);
        @(negedge clk);
        send(0, 1'b1, 16'h0002, 4'd1);
        @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            send(1, 1'b1, 16'(i), 4'(i));
            repeat (R + 2) @(negedge clk);
        end
        total++;
        if (steal_count !== 8'd255) begin
            bad++;
            $display("FAIL steal_255 got=%0d want=255", steal_count);
        end
        send(1, 1'b1, 16'hFFFF, 4'(255));
        repeat (R + 2) @(negedge clk);
        total++;
        if (steal_count !== 8'd255) begin
            bad++;
            $display("FAIL steal_sat got=%0d want=255", steal_count);
        end
        total++;
        if (voice_gate !== 2'b11) begin
            bad++;
            $display("FAIL steal_sat_gate got=%b want=11", voice_gate);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_note_on();
        test_steal();
        test_retrigger();
        test_reset_in_gap();
        test_steal_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
